mem_port_arbiter: RTL and testbench

// - Shares the single data-memory port between instruction fetch (IF, read-only) and load/store (DM, read/write).
// - Sits between the Control/Datapath requesters and the Memory block; one outstanding transaction at a time.
// - DM has priority; a starvation guard bounds IF wait; a timeout guard completes hung transactions.

---
 rtl/riscv_mem_pkg.sv | 29 ++
 rtl/mem_timeout_timer.sv | 36 +++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Covers FSM states, owner codes, access-size codes and counter widths.
package riscv_mem_pkg;

   localparam int unsigned F3_W     = 3;
   localparam int unsigned TMR_W    = 8;
   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_IF = 2'd1,
      ST_WAIT_DM = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   localparam logic [F3_W-1:0] F3_LB  = 3'd0;
   localparam logic [F3_W-1:0] F3_LH  = 3'd1;
   localparam logic [F3_W-1:0] F3_LW  = 3'd2;
   localparam logic [F3_W-1:0] F3_LBU = 3'd4;
   localparam logic [F3_W-1:0] F3_LHU = 3'd5;
   localparam logic [F3_W-1:0] F3_SB  = 3'd0;
   localparam logic [F3_W-1:0] F3_SH  = 3'd1;
   localparam logic [F3_W-1:0] F3_SW  = 3'd2;

endpackage

// File: rtl/mem_timeout_timer.sv
// Wait-cycle counter for an outstanding memory access.
// expire_c flags the last cycle before the limit is reached; a zero limit disables it.
module mem_timeout_timer
   import riscv_mem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [TMR_W-1:0] limit,
   output logic             expire_c
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != '1)) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_c = enable && (limit != '0) && (cnt_q == (limit - TMR_W'(1)));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and load/store.
// DM has priority, a starvation guard bounds IF wait, a timer aborts hung accesses.
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned STARVE_MAX  = 4,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [F3_W-1:0]   dm_funct3,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [F3_W-1:0]   mem_funct3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              timeout_err
);

   arb_state_e            state_q,       state_d;
   logic [STARVE_W-1:0]   starve_q,      starve_d;
   logic                  mem_req_q,     mem_req_d;
   logic                  mem_we_q,      mem_we_d;
   logic [F3_W-1:0]       mem_funct3_q,  mem_funct3_d;
   logic [ADDR_W-1:0]     mem_addr_q,    mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q,   mem_wdata_d;
   logic [DATA_W-1:0]     if_rdata_q,    if_rdata_d;
   logic                  if_valid_q,    if_valid_d;
   logic [DATA_W-1:0]     dm_rdata_q,    dm_rdata_d;
   logic                  dm_valid_q,    dm_valid_d;
   logic                  busy_q,        busy_d;
   logic                  timeout_err_q, timeout_err_d;

   logic if_eff_c;
   logic starve_hit_c;
   logic tmr_clear_c;
   logic tmr_en_c;
   logic tmr_expire_c;

   // An owner whose completion is pulsing this cycle cannot be re-granted yet.
   assign if_eff_c     = if_req && !if_valid_q;
   assign starve_hit_c = (starve_q == STARVE_W'(STARVE_MAX));
   assign tmr_clear_c  = (state_q == ST_IDLE);
   assign tmr_en_c     = (state_q != ST_IDLE);

   mem_timeout_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clear_c),
      .enable   (tmr_en_c),
      .limit    (TMR_W'(TIMEOUT_CYC)),
      .expire_c (tmr_expire_c)
   );

   always_comb begin
      state_d       = state_q;
      starve_d      = starve_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_funct3_d  = mem_funct3_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      if_rdata_d    = if_rdata_q;
      if_valid_d    = 1'b0;
      dm_rdata_d    = dm_rdata_q;
      dm_valid_d    = 1'b0;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // DM keeps its priority win even in its own completion cycle, so a
            // DM stream only yields to IF through the starvation guard.
            if (dm_req && !(if_eff_c && starve_hit_c)) begin
               if (!dm_valid_q) begin
                  state_d      = ST_WAIT_DM;
                  mem_req_d    = 1'b1;
                  mem_we_d     = dm_we;
                  mem_funct3_d = dm_funct3;
                  mem_addr_d   = dm_addr;
                  mem_wdata_d  = dm_wdata;
                  if (if_eff_c && !starve_hit_c) begin
                     starve_d = starve_q + STARVE_W'(1);
                  end
               end
            end else if (if_eff_c) begin
               state_d      = ST_WAIT_IF;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_funct3_d = F3_LW;
               mem_addr_d   = if_addr;
               mem_wdata_d  = '0;
               starve_d     = '0;
            end
         end

         ST_WAIT_IF, ST_WAIT_DM: begin
            if (mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               if (state_q == ST_WAIT_IF) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end else begin
                  dm_valid_d = 1'b1;
                  dm_rdata_d = mem_we_q ? '0 : mem_rdata;
               end
            end else if (tmr_expire_c) begin
               state_d       = ST_IDLE;
               mem_req_d     = 1'b0;
               timeout_err_d = 1'b1;
               if (state_q == ST_WAIT_IF) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = '0;
               end else begin
                  dm_valid_d = 1'b1;
                  dm_rdata_d = '0;
               end
            end
         end

         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         starve_q      <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_funct3_q  <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_rdata_q    <= '0;
         if_valid_q    <= 1'b0;
         dm_rdata_q    <= '0;
         dm_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         starve_q      <= starve_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_funct3_q  <= mem_funct3_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         if_rdata_q    <= if_rdata_d;
         if_valid_q    <= if_valid_d;
         dm_rdata_q    <= dm_rdata_d;
         dm_valid_q    <= dm_valid_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign if_rdata    = if_rdata_q;
   assign if_valid    = if_valid_q;
   assign dm_rdata    = dm_rdata_q;
   assign dm_valid    = dm_valid_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_funct3  = mem_funct3_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, hand-computed expectations.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [2:0]  dm_funct3 = '0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        mem_req;
   logic        mem_we;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        busy;
   logic        timeout_err;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(8)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until mem_req is seen, bounded; n is the number of edges taken.
   task automatic wait_mem_req(output int n);
      n = 0;
      while (mem_req !== 1'b1 && n < 30) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) step();
      tests_run++;
      if ({mem_req, busy, if_valid, dm_valid, timeout_err, mem_we} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {mem_req, busy, if_valid, dm_valid, timeout_err, mem_we});
      end
      tests_run++;
      if ({mem_addr, mem_wdata, mem_funct3} !== 67'd0) begin
         tests_failed++;
         $display("FAIL reset_mem_bus: addr %h wdata %h f3 %0d expected 0", mem_addr, mem_wdata, mem_funct3);
      end
      tests_run++;
      if ({if_rdata, dm_rdata} !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_rdata: if %h dm %h expected 0", if_rdata, dm_rdata);
      end
      rst = 1'b1;
      step();
      // Spurious ack while idle must be ignored.
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF_0000;
      step();
      mem_ack = 1'b0;
      step();
      tests_run++;
      if ({if_valid, dm_valid, busy, mem_req, timeout_err} !== 5'b0) begin
         tests_failed++;
         $display("FAIL spurious_ack: got %b expected 00000", {if_valid, dm_valid, busy, mem_req, timeout_err});
      end
   endtask

   task automatic test_if_only();
      int n;
      if_req = 1'b1;
      if_addr = 32'h100;
      wait_mem_req(n);
      tests_run++;
      if (n !== 1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL if_issue: lat %0d addr %h we %b busy %b expected 1 00000100 0 1", n, mem_addr, mem_we, busy);
      end
      step();
      tests_run++;
      if (mem_req !== 1'b1 || if_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL if_hold: mem_req %b if_valid %b expected 1 0", mem_req, if_valid);
      end
      step();
      mem_ack = 1'b1;
      mem_rdata = 32'h0050_0093;
      step();
      mem_ack = 1'b0;
      if_req = 1'b0;
      tests_run++;
      if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || mem_req !== 1'b0 || dm_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL if_complete: valid %b rdata %h mem_req %b dm_valid %b expected 1 00500093 0 0",
                  if_valid, if_rdata, mem_req, dm_valid);
      end
      step();
      tests_run++;
      if (if_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL if_pulse_width: valid %b busy %b expected 0 0", if_valid, busy);
      end
   endtask

   task automatic test_simultaneous();
      int n;
      if_req = 1'b1;
      if_addr = 32'h104;
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_funct3 = 3'd2;
      dm_addr = 32'h2000;
      wait_mem_req(n);
      tests_run++;
      if (n !== 1 || mem_addr !== 32'h2000 || mem_funct3 !== 3'd2 || mem_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL sim_dm_first: lat %0d addr %h f3 %0d we %b expected 1 00002000 2 0",
                  n, mem_addr, mem_funct3, mem_we);
      end
      mem_ack = 1'b1;
      mem_rdata = 32'h1122_3344;
      step();
      mem_ack = 1'b0;
      dm_req = 1'b0;
      tests_run++;
      if (dm_valid !== 1'b1 || dm_rdata !== 32'h1122_3344 || if_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL sim_dm_done: valid %b rdata %h if_valid %b expected 1 11223344 0", dm_valid, dm_rdata, if_valid);
      end
      step();
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_funct3 !== 3'd2 || mem_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL sim_if_second: req %b addr %h f3 %0d we %b expected 1 00000104 2 0",
                  mem_req, mem_addr, mem_funct3, mem_we);
      end
      mem_ack = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ack = 1'b0;
      if_req = 1'b0;
      tests_run++;
      if (if_valid !== 1'b1 || if_rdata !== 32'hCAFE_F00D) begin
         tests_failed++;
         $display("FAIL sim_if_done: valid %b rdata %h expected 1 cafef00d", if_valid, if_rdata);
      end
      step();
   endtask

   task automatic test_store();
      int n;
      dm_req = 1'b1;
      dm_we = 1'b1;
      dm_funct3 = 3'd2;
      dm_addr = 32'h2004;
      dm_wdata = 32'hDEAD_BEEF;
      wait_mem_req(n);
      tests_run++;
      if (n !== 1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h2004) begin
         tests_failed++;
         $display("FAIL store_issue: lat %0d we %b wdata %h addr %h expected 1 1 deadbeef 00002004",
                  n, mem_we, mem_wdata, mem_addr);
      end
      mem_ack = 1'b1;
      mem_rdata = 32'h5555_5555;
      step();
      mem_ack = 1'b0;
      dm_req = 1'b0;
      dm_we = 1'b0;
      tests_run++;
      if (dm_valid !== 1'b1 || dm_rdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL store_done: valid %b rdata %h expected 1 00000000", dm_valid, dm_rdata);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      dm_req = 1'b1;
      dm_funct3 = 3'd0;
      dm_addr = 32'h3000;
      wait_mem_req(n);
      mem_ack = 1'b1;
      mem_rdata = 32'h0000_0077;
      step();
      mem_ack = 1'b0;
      dm_addr = 32'h3004;
      tests_run++;
      if (dm_valid !== 1'b1 || dm_rdata !== 32'h77) begin
         tests_failed++;
         $display("FAIL b2b_first: valid %b rdata %h expected 1 00000077", dm_valid, dm_rdata);
      end
      step();
      tests_run++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_gap: mem_req %b busy %b expected 0 0", mem_req, busy);
      end
      step();
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h3004 || mem_funct3 !== 3'd0) begin
         tests_failed++;
         $display("FAIL b2b_second: req %b addr %h f3 %0d expected 1 00003004 0", mem_req, mem_addr, mem_funct3);
      end
      mem_ack = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      step();
      mem_ack = 1'b0;
      dm_req = 1'b0;
      tests_run++;
      if (dm_valid !== 1'b1 || dm_rdata !== 32'h0BAD_F00D) begin
         tests_failed++;
         $display("FAIL b2b_second_done: valid %b rdata %h expected 1 0badf00d", dm_valid, dm_rdata);
      end
      step();
   endtask

   task automatic test_starvation();
      int n;
      logic        exp_dm;
      int          exp_n;
      logic [31:0] exp_addr;
      if_req = 1'b1;
      if_addr = 32'h200;
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_funct3 = 3'd2;
      dm_addr = 32'h4000;
      for (int g = 0; g < 5; g++) begin
         exp_dm   = (g < 4);
         exp_n    = (g == 0 || g == 4) ? 1 : 2;
         exp_addr = exp_dm ? 32'h4000 : 32'h200;
         wait_mem_req(n);
         tests_run++;
         if (n !== exp_n || mem_addr !== exp_addr) begin
            tests_failed++;
            $display("FAIL starve_grant%0d: lat %0d addr %h expected %0d %h", g, n, mem_addr, exp_n, exp_addr);
         end
         if (g == 3) begin
            tests_run++;
            if (dut.starve_q !== 4'd4) begin
               tests_failed++;
               $display("FAIL starve_cnt_full: got %0d expected 4", dut.starve_q);
            end
         end
         if (g == 4) begin
            tests_run++;
            if (dut.starve_q !== 4'd0) begin
               tests_failed++;
               $display("FAIL starve_cnt_clear: got %0d expected 0", dut.starve_q);
            end
         end
         mem_ack = 1'b1;
         mem_rdata = 32'hA0 + 32'(g);
         step();
         mem_ack = 1'b0;
         if (!exp_dm) if_req = 1'b0;
         tests_run++;
         if (dm_valid !== exp_dm || if_valid !== !exp_dm) begin
            tests_failed++;
            $display("FAIL starve_done%0d: dm_valid %b if_valid %b expected %b %b", g, dm_valid, if_valid, exp_dm, !exp_dm);
         end
      end
      // DM slips in during the IF completion cycle.
      wait_mem_req(n);
      tests_run++;
      if (n !== 1 || mem_addr !== 32'h4000) begin
         tests_failed++;
         $display("FAIL starve_dm_after_if: lat %0d addr %h expected 1 00004000", n, mem_addr);
      end
      mem_ack = 1'b1;
      mem_rdata = 32'hBEEF_0001;
      step();
      mem_ack = 1'b0;
      dm_req = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      int n;
      int k;
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_funct3 = 3'd2;
      dm_addr = 32'h5000;
      wait_mem_req(n);
      k = 0;
      while (dm_valid !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      dm_req = 1'b0;
      tests_run++;
      if (n !== 1 || k !== 8) begin
         tests_failed++;
         $display("FAIL timeout_latency: issue %0d abort %0d expected 1 8", n, k);
      end
      tests_run++;
      if (timeout_err !== 1'b1 || dm_rdata !== 32'h0 || mem_req !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_abort: err %b rdata %h mem_req %b busy %b expected 1 00000000 0 0",
                  timeout_err, dm_rdata, mem_req, busy);
      end
      step();
      tests_run++;
      if (timeout_err !== 1'b0 || dm_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_pulse: err %b valid %b expected 0 0", timeout_err, dm_valid);
      end
      step();
      mem_ack = 1'b1;
      mem_rdata = 32'h1357_9BDF;
      step();
      mem_ack = 1'b0;
      tests_run++;
      if ({dm_valid, if_valid, busy, timeout_err} !== 4'b0 || dm_rdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL late_ack: flags %b rdata %h expected 0000 00000000",
                  {dm_valid, if_valid, busy, timeout_err}, dm_rdata);
      end
   endtask

   task automatic test_async_reset();
      int n;
      if_req = 1'b1;
      if_addr = 32'h300;
      wait_mem_req(n);
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if (n !== 1 || mem_req !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: issue %0d mem_req %b busy %b expected 1 0 0", n, mem_req, busy);
      end
      if_req = 1'b0;
      step();
      tests_run++;
      if (if_valid !== 1'b0 || mem_addr !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_no_valid: valid %b addr %h expected 0 00000000", if_valid, mem_addr);
      end
      rst = 1'b1;
      step();
      if_req = 1'b1;
      if_addr = 32'h304;
      wait_mem_req(n);
      tests_run++;
      if (n !== 1 || mem_addr !== 32'h304) begin
         tests_failed++;
         $display("FAIL post_reset_issue: lat %0d addr %h expected 1 00000304", n, mem_addr);
      end
      mem_ack = 1'b1;
      mem_rdata = 32'h1234_5678;
      step();
      mem_ack = 1'b0;
      if_req = 1'b0;
      tests_run++;
      if (if_valid !== 1'b1 || if_rdata !== 32'h1234_5678 || timeout_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_done: valid %b rdata %h err %b expected 1 12345678 0", if_valid, if_rdata, timeout_err);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_if_only();
      test_simultaneous();
      test_store();
      test_back_to_back();
      test_starvation();
      test_timeout();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
      $fatal(1);
   end

endmodule
